ccff_chain_loader: RTL and testbench

- Configuration-chain controller for a logic tile's shift-register memory. It drives the chain's serial head bit and config_enable, and monitors the chain's tail bit.
- Accepts the bitstream as a valid/ready word stream and serialises exactly CHAIN_LEN bits into the chain.
- Optionally re-shifts the same stream while comparing the bits at the chain tail, to verify the load.
- Sits between the bitstream source (configuration port or test bench) and a tile's mux/LUT memory chain.

---
 rtl/ccff_loader_pkg.sv | 7 +
 rtl/ccff_word_serializer.sv | 37 +++
 rtl/ccff_chain_loader.sv | 81 ++++++++
 tb/tb_ccff_chain_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding and sizing helper for the chain loader
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: one-word buffer handing out bits LSB first
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              empty,
  output logic              bit0
);
  localparam int IW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] word_q;
  logic [IW-1:0]     left;
  assign empty = left == '0;
  assign ready = active & empty;
  assign bit0  = word_q[0];
  // flush drops the unused high bits of the last word of a pass
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_q <= '0;
      left   <= '0;
    end else if (flush || !active) left <= '0;
    else if (valid && ready) begin
      word_q <= data;
      left   <= IW'(WORD_W);
    end else if (pop) begin
      word_q <= word_q >> 1;
      left   <= left - IW'(1);
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises a word stream into a configuration chain
// and optionally re-shifts it to verify the bits leaving the chain tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 70,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clock,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);
  state_t        state, state_n;
  logic [BW-1:0] bit_cnt;
  logic          verify_q, checking, empty, bit0, issue, last, accept;
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk   (prog_clock),
    .rst_n (prog_reset_n),
    .active(busy),
    .pop   (issue),
    .flush (last),
    .data  (s_data),
    .valid (s_valid),
    .ready (s_ready),
    .empty (empty),
    .bit0  (bit0)
  );
  always_comb begin
    busy    = state == LOAD || state == VERIFY;
    done    = state == DONE;
    accept  = state == IDLE && start;
    issue   = busy && !empty;
    last    = issue && bit_cnt == LAST;
    state_n = accept ? LOAD
            : last   ? (state == LOAD && verify_q ? VERIFY : DONE)
            : done   ? IDLE
            : state;
  end
  always_ff @(posedge prog_clock or negedge prog_reset_n)
    if (!prog_reset_n) state <= IDLE;
    else state <= state_n;
  // checking marks an enable whose head bit came from the VERIFY pass,
  // so the compare lines up with the shift it accompanies
  always_ff @(posedge prog_clock or negedge prog_reset_n)
    if (!prog_reset_n) begin
      config_enable <= 1'b0;
      checking      <= 1'b0;
      ccff_head     <= 1'b0;
      bit_cnt       <= '0;
      verify_q      <= 1'b0;
      error         <= 1'b0;
      mismatch_cnt  <= '0;
    end else begin
      config_enable <= issue;
      checking      <= issue && state == VERIFY;
      if (issue) ccff_head <= bit0;
      bit_cnt <= last ? '0 : issue ? bit_cnt + BW'(1) : bit_cnt;
      if (accept) begin
        verify_q     <= verify_en;
        error        <= 1'b0;
        mismatch_cnt <= '0;
      end else if (checking && ccff_tail != ccff_head) begin
        error        <= 1'b1;
        mismatch_cnt <= &mismatch_cnt ? mismatch_cnt : mismatch_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench with a chain model and stream-order head check
module tb_ccff_chain_loader;
  localparam int CL = 70, WW = 8, NW = 9;
  logic clk = 0, rst_n = 0, start = 0, verify_en = 0, s_valid = 0, ccff_tail;
  logic [WW-1:0] s_data = '0;
  logic s_ready, ccff_head, config_enable, busy, done, error;
  logic [15:0] mismatch_cnt;
  logic [CL-1:0] chain = '0, exp_chain;
  logic exp_bits[CL];
  logic [WW-1:0] words[NW];
  logic [71:0] base = 72'hC3_00_FF_69_96_0F_F0_3C_A5;
  int seq_en = 0, total = 0, bad = 0;
  bit fault = 0;
  logic start2 = 0, valid2 = 0, ready2, head2, ce2, busy2, done2, err2;
  logic [0:0] data2 = 1'b1;
  logic [3:0] cnt2;
  int en2 = 0;

  always #5 clk = ~clk;
  assign ccff_tail = chain[CL-1];

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(16)) dut (
    .prog_clock(clk), .prog_reset_n(rst_n), .start(start), .verify_en(verify_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .config_enable(config_enable), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .error(error), .mismatch_cnt(mismatch_cnt));

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(1), .CNT_W(4)) dut_small (
    .prog_clock(clk), .prog_reset_n(rst_n), .start(start2), .verify_en(1'b0),
    .s_data(data2), .s_valid(valid2), .s_ready(ready2), .ccff_head(head2),
    .config_enable(ce2), .ccff_tail(1'b0), .busy(busy2), .done(done2),
    .error(err2), .mismatch_cnt(cnt2));

  // chain model: flop 0 at the head, flop CL-1 drives the tail; optional fault after the load pass
  always @(posedge clk) begin
    if (rst_n && start && !busy && !done) seq_en <= 0;
    else if (config_enable) seq_en <= seq_en + 1;
    if (config_enable)
      chain <= {chain[CL-2:0], ccff_head} ^ ((fault && seq_en == CL - 1) ? (CL'(1) << 5) : '0);
  end
  always @(posedge clk) if (ce2) en2 <= en2 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every shift must carry the next stream bit, and never beyond two passes
  always @(negedge clk) if (rst_n) begin
    if (config_enable) begin
      chk("head_seq", ccff_head, exp_bits[seq_en % CL]);
      chk("enable_budget", seq_en < 2 * CL, 1);
    end
    if (s_ready) chk("ready_only_busy", busy, 1);
  end

  task automatic set_stream(input logic [WW-1:0] x);
    for (int w = 0; w < NW; w++) words[w] = base[w*WW +: WW] ^ x;
    for (int k = 0; k < CL; k++) begin
      exp_bits[k] = words[k / WW][k % WW];
      exp_chain[CL-1-k] = exp_bits[k];
    end
  endtask

  task automatic pulse_start(input logic v);
    start = 1; verify_en = v;
    @(negedge clk);
    start = 0; verify_en = 0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit stall);
    int t = 0;
    if (stall) repeat ($urandom_range(0, 3)) begin s_valid = 0; @(negedge clk); end
    s_data = w; s_valid = 1;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    chk("handshake", s_ready, 1);
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic send_stream(input bit stall);
    for (int w = 0; w < NW; w++) send_word(words[w], stall);
  endtask

  task automatic run(input bit v, input bit stall);
    pulse_start(v);
    send_stream(stall);
    if (v) send_stream(stall);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    chk(name, done, 1);
    @(negedge clk);
    chk({name, "_pulse"}, done, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic check_zero(input string name);
    chk(name, {s_ready, ccff_head, config_enable, busy, done, error, mismatch_cnt}, 0);
  endtask

  initial begin
    int t;
    set_stream(8'h00);
    repeat (3) @(negedge clk);
    check_zero("reset_outs");
    rst_n = 1;
    @(negedge clk);
    s_valid = 1; s_data = 8'hFF;
    repeat (2) @(negedge clk);
    chk("idle_ready", s_ready, 0);
    chk("idle_busy", busy, 0);
    s_valid = 0;

    run(0, 0);
    wait_done("t1_done");
    chk("t1_enables", seq_en, CL);
    chk("t1_chain", chain == exp_chain, 1);
    chk("t1_model_bit0", exp_bits[0], 1);
    chk("t1_model_bit69", exp_bits[69], 0);
    chk("t1_tail_bit0", chain[CL-1], 1);
    chk("t1_head_bit69", chain[0], 0);
    chk("t1_error", error, 0);

    set_stream(8'h5A);
    run(1, 0);
    wait_done("t2_done");
    chk("t2_enables", seq_en, 2 * CL);
    chk("t2_error", error, 0);
    chk("t2_cnt", mismatch_cnt, 0);
    chk("t2_chain", chain == exp_chain, 1);

    fault = 1;
    run(1, 0);
    wait_done("t3_done");
    fault = 0;
    chk("t3_enables", seq_en, 2 * CL);
    chk("t3_error", error, 1);
    chk("t3_cnt", mismatch_cnt, 1);
    pulse_start(0);
    chk("t3_clr_error", error, 0);
    chk("t3_clr_cnt", mismatch_cnt, 0);
    send_stream(0);
    wait_done("t3b_done");
    chk("t3b_enables", seq_en, CL);

    set_stream(8'hC7);
    pulse_start(0);
    for (int w = 0; w < NW; w++) begin
      send_word(words[w], 1);
      if (w == 3) pulse_start(1);
    end
    wait_done("t4_done");
    chk("t4_enables", seq_en, CL);
    chk("t4_chain", chain == exp_chain, 1);

    set_stream(8'h33);
    pulse_start(0);
    for (int w = 0; w < 4; w++) send_word(words[w], 0);
    t = 0;
    while (seq_en != 30 && t < 60) begin @(negedge clk); t++; end
    chk("t5_reach30", seq_en, 30);
    chk("t5_enable_pre", config_enable, 1);
    #1 rst_n = 0;
    #1 check_zero("t5_async_reset");
    @(negedge clk);
    check_zero("t5_held_reset");
    rst_n = 1;
    @(negedge clk);
    run(0, 0);
    wait_done("t5_done");
    chk("t5_enables", seq_en, CL);
    chk("t5_chain", chain == exp_chain, 1);

    start2 = 1; valid2 = 1;
    @(negedge clk);
    start2 = 0;
    t = 0;
    while (!done2 && t < 20) begin @(negedge clk); t++; end
    chk("small_done", done2, 1);
    @(negedge clk);
    chk("small_enables", en2, 1);
    chk("small_head", head2, 1);
    chk("small_idle", {busy2, done2, err2}, 0);
    valid2 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
